// File: rtl/hdlc_rx_monitor.sv
// HDLC Rx protocol monitor: checks flag detection, spurious flags and abort reporting,
// counting violations in saturating counters. Optional first-error capture: HDLC_MON_FIRST_ERR_EN.
module hdlc_rx_monitor #(
  parameter int FLAG_LATENCY = 2,
  parameter int CNT_WIDTH    = 8,
  parameter int TS_WIDTH     = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 En,
  input  logic                 Clr,
  input  logic                 Rx,
  input  logic                 Rx_FlagDetect,
  input  logic                 Rx_ValidFrame,
  input  logic                 Rx_AbortDetect,
  input  logic                 Rx_AbortSignal,
  output logic [CNT_WIDTH-1:0] ErrFlagMiss,
  output logic [CNT_WIDTH-1:0] ErrFlagSpur,
  output logic [CNT_WIDTH-1:0] ErrAbort,
  output logic [CNT_WIDTH-1:0] ErrTotal,
  output logic                 ErrPulse,
  output logic                 FirstErrValid,
  output logic [1:0]           FirstErrCode,
  output logic [TS_WIDTH-1:0]  FirstErrTime
);

  localparam logic [7:0]           FLAG_PAT = 8'b0111_1110;
  localparam logic [3:0]           FILL_MAX = 4'd8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0]           b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, b};
    return s[CNT_WIDTH] ? CNT_MAX : s[CNT_WIDTH-1:0];
  endfunction

  logic [7:0]              r_shreg;
  logic [3:0]              r_fill;
  logic [FLAG_LATENCY-1:0] r_flag_p;
  logic                    r_abort_due;

  logic [7:0]              w_shreg_next;
  logic [3:0]              w_fill_next;
  logic [FLAG_LATENCY-1:0] w_flag_p_next;
  logic                    w_flag_seen;
  logic                    w_flag_due;
  logic                    w_armed;
  logic                    w_miss;
  logic                    w_spur;
  logic                    w_abrt;
  logic [1:0]              w_nviol;

  // Flag is recognised on the cycle its final 0 is on Rx, using the post-shift view.
  always_comb begin
    w_shreg_next  = {r_shreg[6:0], Rx};
    w_fill_next   = (r_fill == FILL_MAX) ? FILL_MAX : r_fill + 4'd1;
    w_flag_seen   = En && (w_shreg_next == FLAG_PAT) && (w_fill_next == FILL_MAX);
    w_flag_p_next = r_flag_p << 1;
    w_flag_p_next[0] = w_flag_seen;
  end

  assign w_flag_due = r_flag_p[FLAG_LATENCY-1];
  assign w_armed    = (r_fill == FILL_MAX);

  assign w_miss  = En & w_flag_due & ~Rx_FlagDetect;
  assign w_spur  = En & Rx_FlagDetect & ~w_flag_due & w_armed;
  assign w_abrt  = En & r_abort_due & ~Rx_AbortSignal;
  assign w_nviol = {1'b0, w_miss} + {1'b0, w_spur} + {1'b0, w_abrt};

  // Stage: sampling and due-check pipelines; disabling flushes everything so re-arming
  // always needs eight fresh samples.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_shreg     <= '0;
      r_fill      <= '0;
      r_flag_p    <= '0;
      r_abort_due <= 1'b0;
    end else if (!En) begin
      r_shreg     <= '0;
      r_fill      <= '0;
      r_flag_p    <= '0;
      r_abort_due <= 1'b0;
    end else begin
      r_shreg     <= w_shreg_next;
      r_fill      <= w_fill_next;
      r_flag_p    <= w_flag_p_next;
      r_abort_due <= Rx_AbortDetect & Rx_ValidFrame;
    end
  end

  logic [CNT_WIDTH-1:0] r_miss_cnt;
  logic [CNT_WIDTH-1:0] r_spur_cnt;
  logic [CNT_WIDTH-1:0] r_abrt_cnt;
  logic [CNT_WIDTH-1:0] r_tot_cnt;
  logic                 r_pulse;

  // Stage: violation counters; Clr wins over a same-cycle increment.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_miss_cnt <= '0;
      r_spur_cnt <= '0;
      r_abrt_cnt <= '0;
      r_tot_cnt  <= '0;
      r_pulse    <= 1'b0;
    end else begin
      r_pulse <= w_miss | w_spur | w_abrt;
      if (Clr) begin
        r_miss_cnt <= '0;
        r_spur_cnt <= '0;
        r_abrt_cnt <= '0;
        r_tot_cnt  <= '0;
      end else begin
        r_miss_cnt <= sat_add(r_miss_cnt, {1'b0, w_miss});
        r_spur_cnt <= sat_add(r_spur_cnt, {1'b0, w_spur});
        r_abrt_cnt <= sat_add(r_abrt_cnt, {1'b0, w_abrt});
        r_tot_cnt  <= sat_add(r_tot_cnt, w_nviol);
      end
    end
  end

  assign ErrFlagMiss = r_miss_cnt;
  assign ErrFlagSpur = r_spur_cnt;
  assign ErrAbort    = r_abrt_cnt;
  assign ErrTotal    = r_tot_cnt;
  assign ErrPulse    = r_pulse;

`ifdef HDLC_MON_FIRST_ERR_EN
  logic [TS_WIDTH-1:0] r_ts;
  logic                r_fe_valid;
  logic [1:0]          r_fe_code;
  logic [TS_WIDTH-1:0] r_fe_time;

  // Stage: first-error capture; abort outranks spurious, which outranks miss.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ts       <= '0;
      r_fe_valid <= 1'b0;
      r_fe_code  <= 2'b00;
      r_fe_time  <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
      if (Clr) begin
        r_fe_valid <= 1'b0;
        r_fe_code  <= 2'b00;
        r_fe_time  <= '0;
      end else if (!r_fe_valid && (w_nviol != 2'd0)) begin
        r_fe_valid <= 1'b1;
        r_fe_time  <= r_ts;
        r_fe_code  <= w_abrt ? 2'b11 : (w_spur ? 2'b10 : 2'b01);
      end
    end
  end

  assign FirstErrValid = r_fe_valid;
  assign FirstErrCode  = r_fe_code;
  assign FirstErrTime  = r_fe_time;
`else
  assign FirstErrValid = 1'b0;
  assign FirstErrCode  = 2'b00;
  assign FirstErrTime  = '0;
`endif

endmodule

// File: tb/tb_hdlc_rx_monitor.sv
// Randomised and directed bench for hdlc_rx_monitor against a sample-history reference model.
module tb_hdlc_rx_monitor;
  localparam int L    = 2;
  localparam int W    = 8;
  localparam int TW   = 16;
  localparam int CMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst, en, clr, rx, fdet, vfr, adet, asig;
  logic [W-1:0]  o_miss, o_spur, o_abrt, o_tot;
  logic          o_pulse, o_fev;
  logic [1:0]    o_fec;
  logic [TW-1:0] o_fet;

  hdlc_rx_monitor #(.FLAG_LATENCY(L), .CNT_WIDTH(W), .TS_WIDTH(TW)) dut (
    .Clk(clk), .Rst(rst), .En(en), .Clr(clr), .Rx(rx),
    .Rx_FlagDetect(fdet), .Rx_ValidFrame(vfr), .Rx_AbortDetect(adet), .Rx_AbortSignal(asig),
    .ErrFlagMiss(o_miss), .ErrFlagSpur(o_spur), .ErrAbort(o_abrt), .ErrTotal(o_tot),
    .ErrPulse(o_pulse), .FirstErrValid(o_fev), .FirstErrCode(o_fec), .FirstErrTime(o_fet)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: history of enabled samples, absolute due times for flags.
  int e;
  bit hist[$];
  int pend[$];
  bit ab_pend;
  int m_miss, m_spur, m_ab, m_tot, m_fec, m_fet, ts;
  bit m_pulse, m_fev;
  bit src[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic bit due_now();
    foreach (pend[i]) if (pend[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    e = 0; hist.delete(); pend.delete(); ab_pend = 0;
    m_miss = 0; m_spur = 0; m_ab = 0; m_tot = 0; m_pulse = 0;
    m_fev = 0; m_fec = 0; m_fet = 0; ts = 0;
  endtask

  task automatic model_edge();
    bit miss, spur, ab, due, seen;
    miss = 0; spur = 0; ab = 0;
    if (!en) begin
      hist.delete(); pend.delete(); ab_pend = 0;
    end else begin
      due  = due_now();
      miss = due && !fdet;
      spur = fdet && !due && (hist.size() >= 8);
      ab   = ab_pend && !asig;
      ab_pend = adet && vfr;
      while (pend.size() > 0 && pend[0] <= e) void'(pend.pop_front());
      hist.push_back(rx);
      if (hist.size() > 8) void'(hist.pop_front());
      seen = (hist.size() == 8) && !hist[0] && !hist[7];
      for (int i = 1; i < 7; i++) if (hist.size() == 8 && !hist[i]) seen = 0;
      if (seen) pend.push_back(e + L);
    end
    m_pulse = miss | spur | ab;
    if (clr) begin
      m_miss = 0; m_spur = 0; m_ab = 0; m_tot = 0;
      m_fev = 0; m_fec = 0; m_fet = 0;
    end else begin
      m_miss = sat(m_miss + int'(miss));
      m_spur = sat(m_spur + int'(spur));
      m_ab   = sat(m_ab + int'(ab));
      m_tot  = sat(m_tot + int'(miss) + int'(spur) + int'(ab));
      if (!m_fev && m_pulse) begin
        m_fev = 1; m_fet = ts;
        m_fec = ab ? 3 : (spur ? 2 : 1);
      end
    end
    ts = (ts + 1) % (1 << TW);
    e++;
  endtask

  task automatic check_all();
    chk("ErrFlagMiss", o_miss, m_miss);
    chk("ErrFlagSpur", o_spur, m_spur);
    chk("ErrAbort", o_abrt, m_ab);
    chk("ErrTotal", o_tot, m_tot);
    chk("ErrPulse", o_pulse, m_pulse);
`ifdef HDLC_MON_FIRST_ERR_EN
    chk("FirstErrValid", o_fev, m_fev);
    chk("FirstErrCode", o_fec, m_fec);
    chk("FirstErrTime", o_fet, m_fet);
`else
    chk("FirstErrValid", o_fev, 0);
    chk("FirstErrCode", o_fec, 0);
    chk("FirstErrTime", o_fet, 0);
`endif
  endtask

  task automatic step(input bit r, input bit f, input bit v, input bit a, input bit s,
                      input bit n, input bit c);
    @(negedge clk);
    rx = r; fdet = f; vfr = v; adet = a; asig = s; en = n; clr = c;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; en = 1; clr = 0; rx = 1; fdet = 0; vfr = 0; adet = 0; asig = 0;
    model_reset();
    #1 check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // Flag followed by two idle cycles; the detect answer and clear land on the due cycle.
  task automatic send_flag(input bit fd_ok, input bit c);
    bit [7:0] pat;
    pat = 8'b0111_1110;
    for (int i = 7; i >= 0; i--) step(pat[i], 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, fd_ok, 0, 0, 0, 1, c);
  endtask

  initial begin
    do_reset();

    // Correctly answered flag.
    idle(16);
    send_flag(1, 0);
    chk("t1_total", o_tot, 0);

    // Unanswered flag.
    send_flag(0, 0);
    chk("t2_miss", o_miss, 1);
    chk("t2_total", o_tot, 1);

    // Spurious detect, armed and unarmed.
    idle(3);
    step(1, 1, 0, 0, 0, 1, 0);
    chk("t3_spur", o_spur, 1);
    do_reset();
    idle(2);
    step(1, 1, 0, 0, 0, 1, 0);
    chk("t3_spur_unarmed", o_spur, 0);

    // Abort with and without frame in progress.
    idle(10);
    step(1, 0, 1, 1, 0, 1, 0);
    step(1, 0, 1, 0, 0, 1, 0);
    chk("t4_abort", o_abrt, 1);
    step(1, 0, 0, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("t4_abort_novf", o_abrt, 1);

    // Saturation, clear, clear against a coincident error.
    for (int i = 0; i < 300; i++) send_flag(0, 0);
    chk("t5_sat", o_miss, CMAX);
    step(1, 0, 0, 0, 0, 1, 1);
    chk("t5_clr", o_miss, 0);
    send_flag(0, 1);
    chk("t5_clr_coinc", o_miss, 0);

    // First-error capture: abort at timestamp 40, miss at 60.
    do_reset();
    idle(39);
    step(1, 0, 1, 1, 0, 1, 0);
    step(1, 0, 1, 0, 0, 1, 0);
    idle(10);
    send_flag(0, 0);
`ifdef HDLC_MON_FIRST_ERR_EN
    chk("t6_code", o_fec, 3);
    chk("t6_time", o_fet, 40);
    chk("t6_valid", o_fev, 1);
`else
    chk("t6_code", o_fec, 0);
    chk("t6_time", o_fet, 0);
    chk("t6_valid", o_fev, 0);
`endif

    // Random traffic with enable drops, clears and mid-stream resets.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit r, f, v, a, s, n, c;
      if (cyc % 1300 == 1299) do_reset();
      if (src.size() == 0) begin
        if ($urandom % 3 == 0) begin
          src.push_back(0);
          for (int k = 0; k < 6; k++) src.push_back(1);
          src.push_back(0);
        end else begin
          for (int k = 0; k < 1 + int'($urandom % 6); k++) src.push_back($urandom % 4 != 0);
        end
      end
      r = src.pop_front();
      n = ($urandom % 40 != 0);
      c = ($urandom % 150 == 0);
      f = due_now() ? ($urandom % 10 != 0) : ($urandom % 30 == 0);
      a = ($urandom % 12 == 0);
      v = ($urandom % 4 != 0);
      s = ab_pend ? ($urandom % 5 != 0) : bit'($urandom % 2);
      step(r, f, v, a, s, n, c);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL timeout got=running exp=finished");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "timeout");
  end
endmodule
